sgmii_link_supervisor: RTL

Sequences bring-up and upkeep of the SGMII PCS/PMA link. It holds the external PHY in reset, drives the PCS configuration and auto-negotiation vectors, and pulses AN restart. It then watches the PCS status vector, retries AN on timeout, re-resets the PHY after repeated failures and re-negotiates after sustained link loss. It sits beside the PCS/PMA core in the Ethernet driver, on the free-running system clock, and exports a clean link_up/speed/duplex view to the MAC and host.

---
 rtl/sgmii_link_pkg.sv | 31 +++
 rtl/sgmii_link_supervisor_if.sv | 30 +++
 rtl/link_sup_sync.sv | 18 +
 rtl/sgmii_link_supervisor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sgmii_link_pkg.sv
// Shared types and constants for the SGMII link supervisor.
// Status-bit positions match the PCS/PMA core's status_vector layout.
package sgmii_link_pkg;

  typedef enum logic [2:0] {
    PHY_RESET = 3'd0,
    PHY_WAKE  = 3'd1,
    CONFIG    = 3'd2,
    AN_START  = 3'd3,
    AN_WAIT   = 3'd4,
    LINK_UP   = 3'd5
  } state_t;

  localparam int LINK_STATUS = 0;
  localparam int LINK_SYNC   = 1;
  localparam int PHY_LINK    = 7;
  localparam int SPEED_LO    = 10;
  localparam int DUPLEX      = 12;

  localparam logic [4:0]  CFG_VECTOR_DEF = 5'b10000;
  localparam logic [15:0] AN_ADV_DEF     = 16'h4001;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sgmii_link_supervisor_if.sv
// Supervisor <-> PCS/PMA core bundle: status in, config vectors and strobes out.
// master is the supervisor side, slave is the PCS side.
interface sgmii_link_supervisor_if;

  logic [15:0] status_vector;
  logic [4:0]  configuration_vector;
  logic        configuration_valid;
  logic [15:0] an_adv_config_vector;
  logic        an_adv_config_val;
  logic        an_restart_config;

  modport master (
    input  status_vector,
    output configuration_vector,
    output configuration_valid,
    output an_adv_config_vector,
    output an_adv_config_val,
    output an_restart_config
  );

  modport slave (
    output status_vector,
    input  configuration_vector,
    input  configuration_valid,
    input  an_adv_config_vector,
    input  an_adv_config_val,
    input  an_restart_config
  );

endinterface

// File: rtl/link_sup_sync.sv
// Plain 2-FF synchronizer for quasi-static status bits.
// Deliberately unreset so it maps onto dedicated sync flops.
module link_sup_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock) begin
    meta <= d;
    q    <= meta;
  end

endmodule

// File: rtl/sgmii_link_supervisor.sv
// SGMII bring-up/upkeep sequencer: PHY reset, PCS config, AN restart,
// AN timeout retry, PHY re-reset and link-drop renegotiation.
module sgmii_link_supervisor
  import sgmii_link_pkg::*;
#(
  parameter int          RESET_CYCLES      = 1250,
  parameter int          WAKE_CYCLES       = 125000,
  parameter int          AN_TIMEOUT_CYCLES = 2000000,
  parameter int          MAX_RETRIES       = 3,
  parameter int          DROP_CYCLES       = 1250,
  parameter logic [4:0]  CFG_VECTOR        = CFG_VECTOR_DEF,
  parameter logic [15:0] AN_ADV            = AN_ADV_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    restart_req,
  sgmii_link_supervisor_if.master pcs,
  output logic                    phy_reset_n,
  output logic                    link_up,
  output logic [1:0]              speed,
  output logic                    full_duplex,
  output logic [7:0]              retry_count,
  output logic [2:0]              state
);

  localparam int MAXC = max_of(max_of(RESET_CYCLES, WAKE_CYCLES),
                               max_of(AN_TIMEOUT_CYCLES, DROP_CYCLES));
  localparam int CW = cnt_width(MAXC);
  localparam int AW = cnt_width(MAX_RETRIES);

  localparam logic [CW-1:0] R_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] W_LAST = CW'(WAKE_CYCLES - 1);
  localparam logic [CW-1:0] T_LAST = CW'(AN_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DROP_CYCLES - 1);
  localparam logic [AW-1:0] A_LAST = AW'(MAX_RETRIES - 1);

  state_t        st;
  logic [CW-1:0] cnt;
  logic [AW-1:0] attempt;
  logic [5:0]    sync_in;
  logic [5:0]    sync_out;
  logic          link_ok;
  logic          restart_ok;
  logic          unused_status;

  assign sync_in = {
    pcs.status_vector[DUPLEX],
    pcs.status_vector[SPEED_LO+1:SPEED_LO],
    pcs.status_vector[PHY_LINK],
    pcs.status_vector[LINK_SYNC],
    pcs.status_vector[LINK_STATUS]
  };

  assign unused_status = ^{pcs.status_vector[15:13],
                           pcs.status_vector[9:8],
                           pcs.status_vector[6:2]};

  link_sup_sync #(.WIDTH(6)) u_sync (
    .clock (clock),
    .d     (sync_in),
    .q     (sync_out)
  );

  assign link_ok    = &sync_out[2:0];
  assign state      = st;
  assign restart_ok = restart_req &&
                      (st inside {CONFIG, AN_START, AN_WAIT, LINK_UP});

  always_ff @(posedge clock) begin
    if (reset) begin
      st                       <= PHY_RESET;
      cnt                      <= '0;
      attempt                  <= '0;
      phy_reset_n              <= 1'b0;
      pcs.configuration_vector <= '0;
      pcs.configuration_valid  <= 1'b0;
      pcs.an_adv_config_vector <= '0;
      pcs.an_adv_config_val    <= 1'b0;
      pcs.an_restart_config    <= 1'b0;
      link_up                  <= 1'b0;
      speed                    <= '0;
      full_duplex              <= 1'b0;
      retry_count              <= '0;
    end else begin
      pcs.configuration_valid <= 1'b0;
      pcs.an_adv_config_val   <= 1'b0;
      pcs.an_restart_config   <= 1'b0;
      // host restart pre-empts any timeout or drop in the same cycle
      if (restart_ok) begin
        st                    <= AN_START;
        cnt                   <= '0;
        pcs.an_restart_config <= 1'b1;
        link_up               <= 1'b0;
      end else begin
        unique case (st)
          PHY_RESET: begin
            if (cnt == R_LAST) begin
              st          <= PHY_WAKE;
              cnt         <= '0;
              phy_reset_n <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PHY_WAKE: begin
            if (cnt == W_LAST) begin
              st                       <= CONFIG;
              cnt                      <= '0;
              pcs.configuration_vector <= CFG_VECTOR;
              pcs.an_adv_config_vector <= AN_ADV;
              pcs.configuration_valid  <= 1'b1;
              pcs.an_adv_config_val    <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          CONFIG: begin
            st                    <= AN_START;
            cnt                   <= '0;
            pcs.an_restart_config <= 1'b1;
          end
          AN_START: begin
            st  <= AN_WAIT;
            cnt <= '0;
          end
          AN_WAIT: begin
            if (link_ok) begin
              st          <= LINK_UP;
              cnt         <= '0;
              attempt     <= '0;
              link_up     <= 1'b1;
              speed       <= sync_out[4:3];
              full_duplex <= sync_out[5];
            end else if (cnt == T_LAST) begin
              cnt <= '0;
              if (retry_count != 8'hFF) begin
                retry_count <= retry_count + 8'd1;
              end
              // last tolerated timeout escalates to a full PHY reset
              if (attempt == A_LAST) begin
                st          <= PHY_RESET;
                attempt     <= '0;
                phy_reset_n <= 1'b0;
              end else begin
                st                    <= AN_START;
                attempt               <= attempt + 1'b1;
                pcs.an_restart_config <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          LINK_UP: begin
            if (link_ok) begin
              cnt <= '0;
            end else if (cnt == D_LAST) begin
              st                    <= AN_START;
              cnt                   <= '0;
              link_up               <= 1'b0;
              pcs.an_restart_config <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            st          <= PHY_RESET;
            cnt         <= '0;
            phy_reset_n <= 1'b0;
            link_up     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
